// File: rtl/j1_irq_controller.sv
// j1_irq_controller: edge-triggered interrupt controller on the J1 IO bus.
// Sources are synchronized and edge-detected.  Each detected edge latches
// a pending bit.  The CPU sees a registered request whenever an enabled
// pending bit exists and the global enable is set.  Reading CAUSE returns
// the lowest enabled pending source and acknowledges it.
`timescale 1ns/1ps
module j1_irq_controller #(
  parameter logic [15:0] BASE = 16'h0040,
  parameter int          NSRC = 8
) (
  input  logic            clk,
  input  logic            resetq,
  input  logic [NSRC-1:0] irq_src,
  input  logic            io_rd,
  input  logic            io_wr,
  input  logic [15:0]     io_addr,
  input  logic [15:0]     io_dout,
  output logic [15:0]     io_din,
  output logic            interrupt_request
);

  localparam logic [2:0] REG_PENDING = 3'd0;
  localparam logic [2:0] REG_ENABLE  = 3'd1;
  localparam logic [2:0] REG_CAUSE   = 3'd2;
  localparam logic [2:0] REG_SWTRIG  = 3'd3;
  localparam logic [2:0] REG_OVERRUN = 3'd4;
  localparam logic [NSRC-1:0] ONE_V  = NSRC'(1'b1);

  // Zero-extend a source-wide vector to the 16-bit bus.
  function automatic logic [15:0] widen(input logic [NSRC-1:0] v);
    logic [15:0] r;
    r = 16'h0000;
    r[NSRC-1:0] = v;
    return r;
  endfunction

  // Index of the lowest set bit (0 when none set).
  function automatic logic [2:0] lowest_index(input logic [NSRC-1:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = i[2:0];
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  logic [NSRC-1:0] s1_r, s2_r, s3_r;
  logic [NSRC-1:0] pending_r, overrun_r, enable_mask_r;
  logic            enable_global_r;
  logic            irq_r;

  logic            hit_s;
  logic [2:0]      sel_s;
  logic [NSRC-1:0] rise_s, masked_s, ack_clr_s, wr_clr_s, sw_set_s, ovr_clr_s;
  logic [NSRC-1:0] pend_clr_s, pending_next_s, overrun_next_s;
  logic            cause_valid_s, wr_enable_s;
  logic [2:0]      cause_idx_s;
  logic [15:0]     cause_word_s, rd_data_s;
  logic            unused_s;

  assign unused_s = ^{io_addr[0], io_dout};
  assign interrupt_request = irq_r;

  // Decode, edge detect, acknowledge and next-state for pending/overrun.
  always_comb begin
    hit_s       = (io_addr[15:4] == BASE[15:4]);
    sel_s       = io_addr[3:1];
    rise_s      = s2_r & ~s3_r;
    masked_s    = pending_r & enable_mask_r;
    cause_valid_s = |masked_s;
    cause_idx_s = lowest_index(masked_s);
    if (cause_valid_s) begin
      cause_word_s = {1'b1, 12'h000, cause_idx_s};
    end else begin
      cause_word_s = 16'h0000;
    end
    // Isolate the lowest set bit as the one-hot acknowledge mask.
    if (io_rd && hit_s && (sel_s == REG_CAUSE) && cause_valid_s) begin
      ack_clr_s = masked_s & (~masked_s + ONE_V);
    end else begin
      ack_clr_s = '0;
    end
    if (io_wr && hit_s && (sel_s == REG_PENDING)) begin
      wr_clr_s = io_dout[NSRC-1:0];
    end else begin
      wr_clr_s = '0;
    end
    if (io_wr && hit_s && (sel_s == REG_SWTRIG)) begin
      sw_set_s = io_dout[NSRC-1:0];
    end else begin
      sw_set_s = '0;
    end
    if (io_wr && hit_s && (sel_s == REG_OVERRUN)) begin
      ovr_clr_s = io_dout[NSRC-1:0];
    end else begin
      ovr_clr_s = '0;
    end
    wr_enable_s    = io_wr && hit_s && (sel_s == REG_ENABLE);
    pend_clr_s     = wr_clr_s | ack_clr_s;
    pending_next_s = (pending_r & ~pend_clr_s) | rise_s | sw_set_s;
    overrun_next_s = (overrun_r & ~ovr_clr_s) | (rise_s & pending_r & ~pend_clr_s);
  end

  // Read mux; the bus is driven to zero unless this block is being read.
  always_comb begin
    case (sel_s)
      REG_PENDING: rd_data_s = widen(pending_r);
      REG_ENABLE:  rd_data_s = widen(enable_mask_r) | {enable_global_r, 15'h0000};
      REG_CAUSE:   rd_data_s = cause_word_s;
      REG_SWTRIG:  rd_data_s = 16'h0000;
      REG_OVERRUN: rd_data_s = widen(overrun_r);
      default:     rd_data_s = 16'h0000;
    endcase
    if (io_rd && hit_s) begin
      io_din = rd_data_s;
    end else begin
      io_din = 16'h0000;
    end
  end

  // Synchronizer, register state and the registered CPU request.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      s1_r            <= '0;
      s2_r            <= '0;
      s3_r            <= '0;
      pending_r       <= '0;
      overrun_r       <= '0;
      enable_mask_r   <= '0;
      enable_global_r <= 1'b0;
      irq_r           <= 1'b0;
    end else begin
      s1_r      <= irq_src;
      s2_r      <= s1_r;
      s3_r      <= s2_r;
      pending_r <= pending_next_s;
      overrun_r <= overrun_next_s;
      if (wr_enable_s) begin
        enable_mask_r   <= io_dout[NSRC-1:0];
        enable_global_r <= io_dout[15];
      end else begin
        enable_mask_r   <= enable_mask_r;
        enable_global_r <= enable_global_r;
      end
      // Request follows the state in effect before this edge.
      irq_r <= enable_global_r & (|(pending_r & enable_mask_r));
    end
  end

endmodule

// File: tb/tb_j1_irq_controller.sv
// Directed testbench for j1_irq_controller (BASE=16'h0040, NSRC=8).
`timescale 1ns/1ps
module tb_j1_irq_controller;

  localparam logic [15:0] A_PEND = 16'h0040;
  localparam logic [15:0] A_EN   = 16'h0042;
  localparam logic [15:0] A_CAUS = 16'h0044;
  localparam logic [15:0] A_SW   = 16'h0046;
  localparam logic [15:0] A_OVR  = 16'h0048;
  localparam logic [15:0] A_OFF6 = 16'h004C;
  localparam logic [15:0] A_MISS = 16'h0050;

  logic        clk = 1'b0;
  logic        resetq;
  logic [7:0]  irq_src;
  logic        io_rd, io_wr;
  logic [15:0] io_addr, io_dout, io_din;
  logic        interrupt_request;

  int checks = 0;
  int errors = 0;
  logic [15:0] d;

  j1_irq_controller dut (
    .clk(clk), .resetq(resetq), .irq_src(irq_src),
    .io_rd(io_rd), .io_wr(io_wr), .io_addr(io_addr), .io_dout(io_dout),
    .io_din(io_din), .interrupt_request(interrupt_request)
  );

  always #5 clk = ~clk;

  // Combinational look at a register without crossing a clock edge.
  task automatic peek(input logic [15:0] a, output logic [15:0] v);
    io_addr = a; io_rd = 1'b1;
    #1 v = io_din;
    io_rd = 1'b0;
  endtask

  // One-cycle bus write, entered and left just after a falling edge.
  task automatic bus_write(input logic [15:0] a, input logic [15:0] v);
    io_addr = a; io_dout = v; io_wr = 1'b1;
    @(negedge clk);
    io_wr = 1'b0;
  endtask

  // One-cycle bus read spanning a rising edge (side effects take place).
  task automatic bus_read(input logic [15:0] a, output logic [15:0] v);
    io_addr = a; io_rd = 1'b1;
    #1 v = io_din;
    @(negedge clk);
    io_rd = 1'b0;
  endtask

  task automatic test_reset;
    resetq = 1'b0; irq_src = 8'h00; io_rd = 1'b0; io_wr = 1'b0;
    io_addr = 16'h0000; io_dout = 16'h0000;
    #12;
    checks++; if (interrupt_request !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", interrupt_request); end
    peek(A_PEND, d); checks++; if (d !== 16'h0000) begin errors++; $display("FAIL reset_pending: got %h expected 0000", d); end
    peek(A_EN, d);   checks++; if (d !== 16'h0000) begin errors++; $display("FAIL reset_enable: got %h expected 0000", d); end
    @(negedge clk); resetq = 1'b1;
    @(negedge clk);
    peek(A_OVR, d);  checks++; if (d !== 16'h0000) begin errors++; $display("FAIL post_reset_overrun: got %h expected 0000", d); end
    peek(A_CAUS, d); checks++; if (d !== 16'h0000) begin errors++; $display("FAIL post_reset_cause: got %h expected 0000", d); end
    @(negedge clk);
  endtask

  task automatic test_basic_latency;
    bus_write(A_EN, 16'h8001);
    peek(A_EN, d); checks++; if (d !== 16'h8001) begin errors++; $display("FAIL enable_rb: got %h expected 8001", d); end
    irq_src[0] = 1'b1;
    @(negedge clk);
    peek(A_PEND, d); checks++; if (d !== 16'h0000) begin errors++; $display("FAIL lat_k: got %h expected 0000", d); end
    @(negedge clk);
    peek(A_PEND, d); checks++; if (d !== 16'h0000) begin errors++; $display("FAIL lat_k1: got %h expected 0000", d); end
    @(negedge clk);
    peek(A_PEND, d); checks++; if (d !== 16'h0001) begin errors++; $display("FAIL lat_k2_pend: got %h expected 0001", d); end
    checks++; if (interrupt_request !== 1'b0) begin errors++; $display("FAIL lat_k2_req: got %b expected 0", interrupt_request); end
    irq_src[0] = 1'b0;
    @(negedge clk);
    checks++; if (interrupt_request !== 1'b1) begin errors++; $display("FAIL lat_k3_req: got %b expected 1", interrupt_request); end
    peek(A_MISS, d); checks++; if (d !== 16'h0000) begin errors++; $display("FAIL addr_miss: got %h expected 0000", d); end
    bus_write(A_PEND, 16'h0001);
    peek(A_PEND, d); checks++; if (d !== 16'h0000) begin errors++; $display("FAIL w1c_pend: got %h expected 0000", d); end
    checks++; if (interrupt_request !== 1'b1) begin errors++; $display("FAIL req_hold: got %b expected 1", interrupt_request); end
    @(negedge clk);
    checks++; if (interrupt_request !== 1'b0) begin errors++; $display("FAIL req_fall: got %b expected 0", interrupt_request); end
  endtask

  task automatic test_cause;
    bus_write(A_EN, 16'h8006);
    bus_write(A_SW, 16'h0006);
    peek(A_PEND, d); checks++; if (d !== 16'h0006) begin errors++; $display("FAIL sw_pend: got %h expected 0006", d); end
    peek(A_SW, d);   checks++; if (d !== 16'h0000) begin errors++; $display("FAIL sw_read: got %h expected 0000", d); end
    peek(A_OVR, d);  checks++; if (d !== 16'h0000) begin errors++; $display("FAIL sw_no_ovr: got %h expected 0000", d); end
    @(negedge clk);
    bus_read(A_CAUS, d); checks++; if (d !== 16'h8001) begin errors++; $display("FAIL cause1: got %h expected 8001", d); end
    peek(A_PEND, d); checks++; if (d !== 16'h0004) begin errors++; $display("FAIL ack1_pend: got %h expected 0004", d); end
    bus_read(A_CAUS, d); checks++; if (d !== 16'h8002) begin errors++; $display("FAIL cause2: got %h expected 8002", d); end
    peek(A_PEND, d); checks++; if (d !== 16'h0000) begin errors++; $display("FAIL ack2_pend: got %h expected 0000", d); end
    checks++; if (interrupt_request !== 1'b1) begin errors++; $display("FAIL cause_req_hold: got %b expected 1", interrupt_request); end
    @(negedge clk);
    checks++; if (interrupt_request !== 1'b0) begin errors++; $display("FAIL cause_req_fall: got %b expected 0", interrupt_request); end
    bus_read(A_CAUS, d); checks++; if (d !== 16'h0000) begin errors++; $display("FAIL cause_empty: got %h expected 0000", d); end
  endtask

  task automatic test_overrun;
    irq_src[3] = 1'b1;
    repeat (3) @(negedge clk);
    peek(A_PEND, d); checks++; if (d !== 16'h0008) begin errors++; $display("FAIL masked_pend: got %h expected 0008", d); end
    checks++; if (interrupt_request !== 1'b0) begin errors++; $display("FAIL masked_req: got %b expected 0", interrupt_request); end
    irq_src[3] = 1'b0;
    repeat (2) @(negedge clk);
    irq_src[3] = 1'b1;
    repeat (3) @(negedge clk);
    irq_src[3] = 1'b0;
    peek(A_OVR, d); checks++; if (d !== 16'h0008) begin errors++; $display("FAIL overrun_set: got %h expected 0008", d); end
    bus_write(A_OVR, 16'h0008);
    peek(A_OVR, d); checks++; if (d !== 16'h0000) begin errors++; $display("FAIL overrun_clr: got %h expected 0000", d); end
    bus_write(A_EN, 16'h8008);
    checks++; if (interrupt_request !== 1'b0) begin errors++; $display("FAIL late_en_req0: got %b expected 0", interrupt_request); end
    @(negedge clk);
    checks++; if (interrupt_request !== 1'b1) begin errors++; $display("FAIL late_en_req1: got %b expected 1", interrupt_request); end
    bus_write(A_PEND, 16'h00FF);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_set_wins;
    bus_write(A_SW, 16'h0001);
    irq_src[0] = 1'b1;
    repeat (2) @(negedge clk);
    bus_write(A_PEND, 16'h0001);
    peek(A_PEND, d); checks++; if (d !== 16'h0001) begin errors++; $display("FAIL set_wins: got %h expected 0001", d); end
    peek(A_OVR, d);  checks++; if (d !== 16'h0000) begin errors++; $display("FAIL set_wins_ovr: got %h expected 0000", d); end
    irq_src[0] = 1'b0;
    bus_write(A_PEND, 16'hFFFF);
    peek(A_PEND, d); checks++; if (d !== 16'h0000) begin errors++; $display("FAIL pend_all_clr: got %h expected 0000", d); end
  endtask

  task automatic test_enable_bits;
    bus_write(A_EN, 16'hFFFF);
    peek(A_EN, d); checks++; if (d !== 16'h80FF) begin errors++; $display("FAIL enable_unused: got %h expected 80ff", d); end
    bus_write(A_EN, 16'h0001);
    peek(A_EN, d); checks++; if (d !== 16'h0001) begin errors++; $display("FAIL enable_noglobal: got %h expected 0001", d); end
  endtask

  task automatic test_global_off;
    bus_write(A_SW, 16'h0001);
    peek(A_PEND, d); checks++; if (d !== 16'h0001) begin errors++; $display("FAIL goff_pend: got %h expected 0001", d); end
    repeat (2) @(negedge clk);
    checks++; if (interrupt_request !== 1'b0) begin errors++; $display("FAIL goff_req: got %b expected 0", interrupt_request); end
    bus_write(A_EN, 16'h8001);
    @(negedge clk);
    checks++; if (interrupt_request !== 1'b1) begin errors++; $display("FAIL gon_req: got %b expected 1", interrupt_request); end
  endtask

  task automatic test_back_to_back;
    io_addr = A_PEND; io_dout = 16'h0001; io_wr = 1'b1; io_rd = 1'b1;
    #1 d = io_din;
    checks++; if (d !== 16'h0001) begin errors++; $display("FAIL rw_pre: got %h expected 0001", d); end
    @(negedge clk);
    io_wr = 1'b0; io_rd = 1'b0;
    peek(A_PEND, d); checks++; if (d !== 16'h0000) begin errors++; $display("FAIL rw_post: got %h expected 0000", d); end
    bus_write(A_SW, 16'h0001);
    repeat (2) @(negedge clk);
    checks++; if (interrupt_request !== 1'b1) begin errors++; $display("FAIL pre_rst_req: got %b expected 1", interrupt_request); end
  endtask

  task automatic test_async_reset;
    irq_src[2] = 1'b1;
    #2 resetq = 1'b0;
    #1;
    checks++; if (interrupt_request !== 1'b0) begin errors++; $display("FAIL arst_req: got %b expected 0", interrupt_request); end
    peek(A_PEND, d); checks++; if (d !== 16'h0000) begin errors++; $display("FAIL arst_pend: got %h expected 0000", d); end
    peek(A_EN, d);   checks++; if (d !== 16'h0000) begin errors++; $display("FAIL arst_en: got %h expected 0000", d); end
    peek(A_OFF6, d); checks++; if (d !== 16'h0000) begin errors++; $display("FAIL off6: got %h expected 0000", d); end
    @(negedge clk); resetq = 1'b1;
    repeat (3) @(negedge clk);
    peek(A_PEND, d); checks++; if (d !== 16'h0004) begin errors++; $display("FAIL held_src_pend: got %h expected 0004", d); end
    repeat (3) @(negedge clk);
    peek(A_OVR, d);  checks++; if (d !== 16'h0000) begin errors++; $display("FAIL held_src_ovr: got %h expected 0000", d); end
    irq_src[2] = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_latency();
    test_cause();
    test_overrun();
    test_set_wins();
    test_enable_bits();
    test_global_off();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
